// File: rtl/deck_dealer.sv
// Deck receiver: captures a shuffled card stream, checks it for range and duplicate
// errors, then deals the stored cards in order with rank, suit and points decoded.
module deck_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int CARD_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadFlag,
    input  logic [CARD_W-1:0] card,
    input  logic              newDeck,
    input  logic              dealReq,
    output logic              deckReady,
    output logic              deckEmpty,
    output logic              dealValid,
    output logic [CARD_W-1:0] dealtCard,
    output logic [3:0]        dealtRank,
    output logic [1:0]        dealtSuit,
    output logic [3:0]        dealtPoints,
    output logic              loadError
);

    typedef enum logic [1:0] {LOAD, READY, EMPTY} state_t;

    localparam logic [CARD_W-1:0] LAST = CARD_W'(DECK_SIZE - 1);

    state_t               state;
    logic [CARD_W-1:0]    deck [DECK_SIZE];
    logic [CARD_W-1:0]    wr_ptr;
    logic [CARD_W-1:0]    rd_ptr;
    logic [DECK_SIZE-1:0] seen;

    logic                 card_ok;
    logic                 accept;
    logic [CARD_W-1:0]    cur_card;
    logic [CARD_W-1:0]    cur_rem;
    logic [1:0]           cur_suit;
    logic [3:0]           cur_rank;
    logic [3:0]           cur_points;

    // The range test is evaluated first so seen[] is only consulted for legal codes.
    always_comb begin
        card_ok = (card <= LAST) && !seen[card];
        accept  = !rst && !newDeck && (state == LOAD) && loadFlag && card_ok;
    end

    // Divide/modulo by 13 via a short ladder of constant compares and subtracts.
    always_comb begin
        cur_card = deck[rd_ptr];
        if (cur_card >= CARD_W'(39)) begin
            cur_suit = 2'd3;
            cur_rem  = cur_card - CARD_W'(39);
        end else if (cur_card >= CARD_W'(26)) begin
            cur_suit = 2'd2;
            cur_rem  = cur_card - CARD_W'(26);
        end else if (cur_card >= CARD_W'(13)) begin
            cur_suit = 2'd1;
            cur_rem  = cur_card - CARD_W'(13);
        end else begin
            cur_suit = 2'd0;
            cur_rem  = cur_card;
        end
        cur_rank   = cur_rem[3:0] + 4'd1;
        cur_points = (cur_rank > 4'd10) ? 4'd10 : cur_rank;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            deck[wr_ptr] <= card;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            seen        <= '0;
            loadError   <= 1'b0;
            dealValid   <= 1'b0;
            dealtCard   <= '0;
            dealtRank   <= 4'd0;
            dealtSuit   <= 2'd0;
            dealtPoints <= 4'd0;
        end else begin
            dealValid <= 1'b0;
            if (newDeck) begin
                state     <= LOAD;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                seen      <= '0;
                loadError <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (loadFlag) begin
                            if (card_ok) begin
                                seen[card] <= 1'b1;
                                wr_ptr     <= wr_ptr + 1'b1;
                                if (wr_ptr == LAST) begin
                                    state <= READY;
                                end
                            end else begin
                                loadError <= 1'b1;
                            end
                        end
                    end
                    READY: begin
                        if (dealReq) begin
                            dealValid   <= 1'b1;
                            dealtCard   <= cur_card;
                            dealtRank   <= cur_rank;
                            dealtSuit   <= cur_suit;
                            dealtPoints <= cur_points;
                            rd_ptr      <= rd_ptr + 1'b1;
                            if (rd_ptr == LAST) begin
                                state <= EMPTY;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign deckReady = (state == READY);
    assign deckEmpty = (state == EMPTY);

endmodule

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer: load/deal sequences, error cases, newDeck and reset.
module tb_deck_dealer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       loadFlag = 1'b0;
    logic [5:0] card = 6'd0;
    logic       newDeck = 1'b0;
    logic       dealReq = 1'b0;
    logic       deckReady;
    logic       deckEmpty;
    logic       dealValid;
    logic [5:0] dealtCard;
    logic [3:0] dealtRank;
    logic [1:0] dealtSuit;
    logic [3:0] dealtPoints;
    logic       loadError;

    int total  = 0;
    int passed = 0;

    deck_dealer #(.DECK_SIZE(52), .CARD_W(6)) dut (
        .clk(clk), .rst(rst), .loadFlag(loadFlag), .card(card),
        .newDeck(newDeck), .dealReq(dealReq), .deckReady(deckReady),
        .deckEmpty(deckEmpty), .dealValid(dealValid), .dealtCard(dealtCard),
        .dealtRank(dealtRank), .dealtSuit(dealtSuit), .dealtPoints(dealtPoints),
        .loadError(loadError)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic load_card(input logic [5:0] c);
        loadFlag = 1'b1;
        card     = c;
        tick();
        loadFlag = 1'b0;
    endtask

    task automatic deal();
        dealReq = 1'b1;
        tick();
        dealReq = 1'b0;
    endtask

    task automatic pulse_new_deck();
        newDeck = 1'b1;
        tick();
        newDeck = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(deckReady),   0);
        check({tag, "_empty"},  32'(deckEmpty),   0);
        check({tag, "_valid"},  32'(dealValid),   0);
        check({tag, "_card"},   32'(dealtCard),   0);
        check({tag, "_rank"},   32'(dealtRank),   0);
        check({tag, "_suit"},   32'(dealtSuit),   0);
        check({tag, "_points"}, 32'(dealtPoints), 0);
        check({tag, "_err"},    32'(loadError),   0);
    endtask

    initial begin
        int exp_rank;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // In-order load 0..51
        for (int i = 0; i < 52; i++) begin
            load_card(6'(i));
            if (i == 50) check("ready_before_last", 32'(deckReady), 0);
        end
        check("ready_after_52", 32'(deckReady), 1);
        check("err_clean_load", 32'(loadError), 0);

        // Deal all 52 back to back; decode checked against card%13 model
        for (int i = 0; i < 52; i++) begin
            deal();
            exp_rank = i % 13 + 1;
            check($sformatf("deal%0d_valid", i), 32'(dealValid), 1);
            check($sformatf("deal%0d_card", i), 32'(dealtCard), 32'(i));
            check($sformatf("deal%0d_rank", i), 32'(dealtRank), 32'(exp_rank));
            check($sformatf("deal%0d_suit", i), 32'(dealtSuit), 32'(i / 13));
            check($sformatf("deal%0d_points", i), 32'(dealtPoints),
                  32'((exp_rank > 10) ? 10 : exp_rank));
            if (i == 12) begin
                check("king12_rank", 32'(dealtRank), 13);
                check("king12_suit", 32'(dealtSuit), 0);
                check("king12_points", 32'(dealtPoints), 10);
            end
            if (i == 13) begin
                check("ace13_rank", 32'(dealtRank), 1);
                check("ace13_suit", 32'(dealtSuit), 1);
                check("ace13_points", 32'(dealtPoints), 1);
            end
            if (i == 50) check("empty_before_last", 32'(deckEmpty), 0);
        end
        check("empty_after_52", 32'(deckEmpty), 1);
        check("ready_after_52_deals", 32'(deckReady), 0);
        tick();
        check("valid_drops", 32'(dealValid), 0);
        deal();
        check("deal53_no_valid", 32'(dealValid), 0);
        check("deal53_card_holds", 32'(dealtCard), 51);

        // Duplicate card 5 in the stream
        pulse_new_deck();
        check("nd_empty_clear", 32'(deckEmpty), 0);
        for (int i = 0; i <= 10; i++) load_card(6'(i));
        check("dup_err_before", 32'(loadError), 0);
        load_card(6'd5);
        check("dup_err_set", 32'(loadError), 1);
        for (int i = 11; i < 52; i++) begin
            load_card(6'(i));
            if (i == 50) check("dup_ready_before_last", 32'(deckReady), 0);
        end
        check("dup_ready", 32'(deckReady), 1);
        check("dup_err_sticky", 32'(loadError), 1);
        for (int i = 0; i < 12; i++) deal();
        check("dup_deal12_card", 32'(dealtCard), 11);
        check("dup_deal12_rank", 32'(dealtRank), 12);

        // Out-of-range card 60
        pulse_new_deck();
        check("oor_err_cleared", 32'(loadError), 0);
        check("oor_ready_cleared", 32'(deckReady), 0);
        load_card(6'd60);
        check("oor_err_set", 32'(loadError), 1);
        for (int i = 0; i < 52; i++) begin
            load_card(6'(i));
            if (i == 50) check("oor_ready_before_last", 32'(deckReady), 0);
        end
        check("oor_ready", 32'(deckReady), 1);

        // newDeck together with dealReq after 3 deals
        deal();
        deal();
        deal();
        check("pre_nd_card", 32'(dealtCard), 2);
        newDeck = 1'b1;
        dealReq = 1'b1;
        tick();
        newDeck = 1'b0;
        dealReq = 1'b0;
        check("nd_no_valid", 32'(dealValid), 0);
        check("nd_ready_low", 32'(deckReady), 0);
        check("nd_err_low", 32'(loadError), 0);
        for (int i = 51; i >= 0; i--) load_card(6'(i));
        check("rev_ready", 32'(deckReady), 1);
        deal();
        check("rev_first_valid", 32'(dealValid), 1);
        check("rev_first_card", 32'(dealtCard), 51);
        check("rev_first_rank", 32'(dealtRank), 13);
        check("rev_first_suit", 32'(dealtSuit), 3);
        check("rev_first_points", 32'(dealtPoints), 10);
        deal();
        check("rev_second_card", 32'(dealtCard), 50);

        // Reset in the middle of a load
        pulse_new_deck();
        for (int i = 0; i < 20; i++) load_card(6'(i));
        load_card(6'd3);
        rst = 1'b1;
        loadFlag = 1'b1;
        card = 6'd20;
        tick();
        rst = 1'b0;
        loadFlag = 1'b0;
        check_all_zero("midrst");

        // A card arriving with newDeck is discarded, so a full reload stays clean
        newDeck = 1'b1;
        loadFlag = 1'b1;
        card = 6'd0;
        tick();
        newDeck = 1'b0;
        loadFlag = 1'b0;
        for (int i = 0; i < 52; i++) load_card(6'(i));
        check("reload_ready", 32'(deckReady), 1);
        check("reload_err", 32'(loadError), 0);
        deal();
        check("reload_first_card", 32'(dealtCard), 0);
        check("reload_first_valid", 32'(dealValid), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/deck_dealer.md
Name: deck_dealer

Overview:
Receiving end of the shuffler's card stream. It captures the card sequence presented with loadFlag into an internal deck store and checks that the deck is complete and free of duplicates. It then deals cards one at a time to the game controller on request, with rank, suit and blackjack point value decoded. It sits between shuffle and the blackjack game FSM.

Parameters:
DECK_SIZE, 52, number of cards per deck; legal card codes are 0..DECK_SIZE-1
CARD_W, 6, card code width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
loadFlag  in  1  card-valid strobe from shuffler; one card per high cycle
card  in  CARD_W  card code, sampled when loadFlag=1
newDeck  in  1  one-cycle pulse; discard the current deck and re-enter LOAD
dealReq  in  1  one-cycle pulse; request the next card
deckReady  out  1  high in READY
deckEmpty  out  1  high in EMPTY
dealValid  out  1  one-cycle pulse; dealt outputs valid
dealtCard  out  CARD_W  dealt card code
dealtRank  out  4  1..13 (1=A, 11=J, 12=Q, 13=K)
dealtSuit  out  2  dealtCard / 13
dealtPoints  out  4  A=1, 2..10 face value, J/Q/K=10
loadError  out  1  sticky; set on an out-of-range or duplicate card

Behaviour:
- Storage: a DECK_SIZE x CARD_W deck array, a 6-bit write pointer wrPtr, a 6-bit read pointer rdPtr, and a DECK_SIZE-bit seen mask.
- Reset (sync, rst=1 at a clock edge):
  - state=LOAD; wrPtr=0, rdPtr=0, seen=0.
  - All outputs 0; dealtRank, dealtSuit and dealtPoints are 0.
  - Array contents are don't-care.
  - Reset overrides every other input in that cycle, including a mid-load or mid-deal one.
- LOAD state:
  - On loadFlag=1 with card<DECK_SIZE and seen[card]=0: write deck[wrPtr]=card, set seen[card], increment wrPtr.
  - On loadFlag=1 with card>=DECK_SIZE or seen[card]=1: no write, wrPtr holds, loadError<=1.
  - When an accepted write brings wrPtr to DECK_SIZE: go to READY next cycle, so deckReady rises the cycle after the 52nd accepted card.
  - dealReq is ignored in LOAD.
- READY state:
  - On dealReq=1: next cycle dealValid=1 for exactly one cycle. dealtCard=deck[rdPtr]; rank, suit and points are decoded from that card and registered with it (latency 1). rdPtr then increments.
  - The decoded outputs hold their value until the next deal.
  - After the 52nd deal: go to EMPTY (the same edge that asserts dealValid for card 52).
  - loadFlag is ignored in READY.
- EMPTY state:
  - deckEmpty=1; dealReq is ignored (no dealValid).
- newDeck (any state, rst=0):
  - Next cycle: state=LOAD; wrPtr, rdPtr, seen and loadError are cleared; deckReady and deckEmpty go to 0.
  - A loadFlag in the same cycle as newDeck is discarded.
  - A dealReq in the same cycle as newDeck is ignored.
  - newDeck has priority over both.
- loadError:
  - Sticky until rst or newDeck.
  - It does not block completion: the deck still reaches READY once 52 valid cards are accepted.
- Back-to-back dealReq on consecutive cycles is legal: one card per cycle, in stored order.
- Decode: rank = card%13 + 1; suit = card/13; points = rank>10 ? 10 : rank. Division and modulo are done by small constant compare/subtract, with no generic divider.

Test Plan:
- Reset, then 52 loadFlag pulses with card=0..51 in order -> deckReady=1 one cycle after the last card; loadError=0.
- From READY, 52 single dealReq pulses -> dealtCard=0..51 in order, each with dealValid one cycle after its dealReq. For card 12: rank=13, suit=0, points=10. For card 13: rank=1, suit=1, points=1. deckEmpty=1 after the 52nd deal; a 53rd dealReq gives no dealValid.
- Load 0..10, then card 5 again, then 11..51 -> loadError=1; the duplicate is not stored; deckReady after 52 valid cards. Deal 12 cards -> 12th dealtCard=11.
- card=60 with loadFlag=1 during LOAD -> loadError=1; wrPtr unchanged. A subsequent legal stream completes the load.
- In READY after 3 deals, pulse newDeck together with dealReq -> no dealValid; deckReady=0; loadError=0. Reload in reverse order 51..0, then deal -> first dealtCard=51.
- Assert rst in the middle of a load (after 20 cards) -> all outputs 0. A full 52-card reload then reaches READY normally.
